// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA pixel path.
package vga_pkg;

  localparam int H_PIX_DEF = 128;
  localparam int V_PIX_DEF = 96;

  // Counter/coordinate width for a range of n values (never narrower than 1 bit).
  function automatic int pix_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // VRAM addresses are packed {row, col}; the caller truncates to the address width.
  function automatic logic [31:0] pack_addr(input logic [31:0] row,
                                            input logic [31:0] col,
                                            input int          col_w);
    return (row << col_w) | col;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with enable, synchronous clear and terminal-count flag.
module mod_counter
  import vga_pkg::*;
#(
  parameter int N = 4,
  parameter int W = pix_w(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == W'(N - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/vga_pixel_addr_gen.sv
// Converts hde/vde strobes into scaled source coordinates and a prefetched
// VRAM read address, with line/frame pulses and a sticky overrun flag.
module vga_pixel_addr_gen
  import vga_pkg::*;
#(
  parameter int H_PIX       = H_PIX_DEF,
  parameter int V_PIX       = V_PIX_DEF,
  parameter int H_SCALE     = 5,
  parameter int V_SCALE     = 5,
  parameter int CLK_PER_DOT = 4,
  parameter int RAM_LAT     = 2,
  localparam int HW         = pix_w(H_PIX),
  localparam int VW         = pix_w(V_PIX)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hde,
  input  logic             vde,
  output logic [HW-1:0]    HPIXEL,
  output logic [VW-1:0]    VPIXEL,
  output logic [VW+HW-1:0] vram_addr,
  output logic             pixel_valid,
  output logic             line_done,
  output logic             frame_done,
  output logic             pixel_overrun
);

  localparam int PIX_CLKS = CLK_PER_DOT * H_SCALE;
  localparam int FETCH_PT = PIX_CLKS - 1 - RAM_LAT;
  localparam int SW       = pix_w(PIX_CLKS);
  localparam int LW       = pix_w(V_SCALE);
  localparam int AW       = VW + HW;

  logic          hde_q, vde_q;
  logic          act, line_end, tick, wrap;
  logic [SW-1:0] sub_cnt;
  logic          sub_tc;
  logic [LW-1:0] line_cnt_unused;
  logic          line_tc;
  logic [HW-1:0] hpix_d, hfetch;
  logic [VW-1:0] vpix_d;
  // Last legal pixel / row already completed; any further activity is overrun.
  logic          h_full, v_full;

  assign act         = hde & vde;
  assign pixel_valid = act;
  assign line_end    = hde_q & ~hde & vde;
  assign tick        = act & sub_tc;
  assign wrap        = line_end & line_tc;

  mod_counter #(.N(PIX_CLKS), .W(SW)) u_sub_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (act),
    .clr   (~act),
    .cnt   (sub_cnt),
    .tc    (sub_tc)
  );

  mod_counter #(.N(V_SCALE), .W(LW)) u_line_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (line_end),
    .clr   (~vde),
    .cnt   (line_cnt_unused),
    .tc    (line_tc)
  );

  always_comb begin
    hpix_d = HPIXEL;
    if (!vde || line_end) begin
      hpix_d = '0;
    end else if (tick && (HPIXEL != HW'(H_PIX - 1))) begin
      hpix_d = HPIXEL + HW'(1);
    end
  end

  // vpix_d is also the row the next line shows, used for blanking prefetch.
  always_comb begin
    vpix_d = VPIXEL;
    if (!vde) begin
      vpix_d = '0;
    end else if (wrap && (VPIXEL != VW'(V_PIX - 1))) begin
      vpix_d = VPIXEL + VW'(1);
    end
  end

  assign hfetch = (HPIXEL == HW'(H_PIX - 1)) ? HPIXEL : HPIXEL + HW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hde_q         <= 1'b0;
      vde_q         <= 1'b0;
      HPIXEL        <= '0;
      VPIXEL        <= '0;
      vram_addr     <= '0;
      line_done     <= 1'b0;
      frame_done    <= 1'b0;
      h_full        <= 1'b0;
      v_full        <= 1'b0;
      pixel_overrun <= 1'b0;
    end else begin
      hde_q      <= hde;
      vde_q      <= vde;
      HPIXEL     <= hpix_d;
      VPIXEL     <= vpix_d;
      // A line cut short by vde falling still reports its end.
      line_done  <= hde_q & ~hde & (vde | vde_q);
      frame_done <= vde_q & ~vde;

      if (!vde) begin
        vram_addr <= '0;
      end else if (!hde) begin
        vram_addr <= AW'(pack_addr(32'(vpix_d), 32'd0, HW));
      end else if (sub_cnt == SW'(FETCH_PT)) begin
        vram_addr <= AW'(pack_addr(32'(VPIXEL), 32'(hfetch), HW));
      end

      if (!act) begin
        h_full <= 1'b0;
      end else if (tick && (HPIXEL == HW'(H_PIX - 1))) begin
        h_full <= 1'b1;
      end

      if (!vde) begin
        v_full <= 1'b0;
      end else if (wrap && (VPIXEL == VW'(V_PIX - 1))) begin
        v_full <= 1'b1;
      end

      if (act && (h_full || v_full)) begin
        pixel_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_addr_gen.sv
// Directed bench: default-parameter instance plus a fast-scaled RAM_LAT=0 instance.
module tb_vga_pixel_addr_gen;

  localparam int HW = 7;
  localparam int VW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          hde, vde, hde_b, vde_b;
  logic [HW-1:0] hpix, hpix_b;
  logic [VW-1:0] vpix, vpix_b;
  logic [VW+HW-1:0] vram, vram_b;
  logic          pv, pv_b, ld, ld_b, fd, fd_b, ovr, ovr_b;

  int checks = 0;
  int errors = 0;
  int ld_cnt = 0;
  logic [31:0] hexp_q[$];
  logic [31:0] aexp_q[$];
  logic [31:0] bexp_q[$];

  always #5 clk = ~clk;

  vga_pixel_addr_gen #(
    .H_PIX(128), .V_PIX(96), .H_SCALE(5), .V_SCALE(5), .CLK_PER_DOT(4), .RAM_LAT(2)
  ) dut (
    .clk(clk), .reset(reset), .hde(hde), .vde(vde),
    .HPIXEL(hpix), .VPIXEL(vpix), .vram_addr(vram), .pixel_valid(pv),
    .line_done(ld), .frame_done(fd), .pixel_overrun(ovr)
  );

  vga_pixel_addr_gen #(
    .H_PIX(128), .V_PIX(96), .H_SCALE(2), .V_SCALE(5), .CLK_PER_DOT(1), .RAM_LAT(0)
  ) dut_b (
    .clk(clk), .reset(reset), .hde(hde_b), .vde(vde_b),
    .HPIXEL(hpix_b), .VPIXEL(vpix_b), .vram_addr(vram_b), .pixel_valid(pv_b),
    .line_done(ld_b), .frame_done(fd_b), .pixel_overrun(ovr_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One active line on the default instance. Expected HPIXEL and vram_addr
  // changes are queued as {edge_index, value} before hde rises.
  task automatic run_line(input int len, input int row, input bit drop_vde);
    int nh, na, prev_h, prev_a;
    logic [31:0] want;
    nh = (len / 20 > 127) ? 127 : len / 20;
    na = ((len + 2) / 20 > 127) ? 127 : (len + 2) / 20;
    for (int p = 1; p <= nh; p++) hexp_q.push_back({16'(20 * p), 16'(p)});
    for (int p = 1; p <= na; p++) aexp_q.push_back({16'(20 * p - 2), 16'(row * 128 + p)});
    check("vpix_at_line_start", 32'(vpix), 32'(row));
    check("vram_before_line", 32'(vram), 32'(row * 128));
    prev_h = int'(hpix);
    prev_a = int'(vram);
    hde = 1'b1;
    for (int k = 1; k <= len; k++) begin
      step();
      if (k == 1) check("pixel_valid_high", 32'(pv), 32'd1);
      if (int'(hpix) != prev_h) begin
        want = (hexp_q.size() > 0) ? hexp_q.pop_front() : 32'hFFFF_FFFF;
        check("hpix_step", {16'(k), 16'(hpix)}, want);
        prev_h = int'(hpix);
      end
      if (int'(vram) != prev_a) begin
        want = (aexp_q.size() > 0) ? aexp_q.pop_front() : 32'hFFFF_FFFF;
        check("vram_step", {16'(k), 16'(vram)}, want);
        prev_a = int'(vram);
      end
    end
    check("hpix_queue_drained", 32'(hexp_q.size()), 32'd0);
    check("vram_queue_drained", 32'(aexp_q.size()), 32'd0);
    hexp_q.delete();
    aexp_q.delete();
    hde = 1'b0;
    if (drop_vde) vde = 1'b0;
    step();
    ld_cnt += int'(ld);
    check("line_done_pulse", 32'(ld), 32'd1);
    check("hpix_cleared_at_line_end", 32'(hpix), 32'd0);
    check("pixel_valid_low", 32'(pv), 32'd0);
    if (drop_vde) begin
      check("frame_done_pulse", 32'(fd), 32'd1);
      check("vpix_cleared_at_frame_end", 32'(vpix), 32'd0);
    end
    step();
    ld_cnt += int'(ld);
    check("line_done_one_cycle", 32'(ld), 32'd0);
    check("frame_done_one_cycle", 32'(fd), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      ld_cnt += int'(ld);
    end
  endtask

  initial begin
    logic [31:0] e;
    reset = 1'b1;
    hde = 1'b0; vde = 1'b0; hde_b = 1'b0; vde_b = 1'b0;
    #3;
    check("reset_hpix", 32'(hpix), 32'd0);
    check("reset_vpix", 32'(vpix), 32'd0);
    check("reset_vram", 32'(vram), 32'd0);
    check("reset_line_done", 32'(ld), 32'd0);
    check("reset_frame_done", 32'(fd), 32'd0);
    check("reset_overrun", 32'(ovr), 32'd0);
    step(); step();
    reset = 1'b0;
    vde = 1'b1;
    repeat (4) step();

    // Five screen lines share source row 0, the sixth moves to row 1.
    for (int l = 0; l < 5; l++) run_line(2560, 0, 1'b0);
    check("overrun_after_exact_lines", 32'(ovr), 32'd0);
    check("vpix_before_6th_line", 32'(vpix), 32'd1);
    check("vram_prefetch_row1", 32'(vram), 32'd128);
    run_line(2560, 1, 1'b0);
    check("line_done_count", 32'(ld_cnt), 32'd6);
    check("overrun_still_clear", 32'(ovr), 32'd0);

    // Overlong line saturates HPIXEL and latches overrun.
    run_line(2600, 1, 1'b0);
    check("overrun_set", 32'(ovr), 32'd1);
    run_line(2560, 1, 1'b0);
    check("overrun_sticky", 32'(ovr), 32'd1);

    // hde and vde drop together.
    run_line(100, 1, 1'b1);
    check("overrun_sticky_after_frame", 32'(ovr), 32'd1);

    // Asynchronous reset mid-line.
    vde = 1'b1;
    repeat (4) step();
    hde = 1'b1;
    repeat (1280) step();
    check("hpix_mid_line", 32'(hpix), 32'd64);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_hpix", 32'(hpix), 32'd0);
    check("async_reset_vpix", 32'(vpix), 32'd0);
    check("async_reset_vram", 32'(vram), 32'd0);
    check("async_reset_line_done", 32'(ld), 32'd0);
    check("async_reset_frame_done", 32'(fd), 32'd0);
    check("async_reset_overrun", 32'(ovr), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (19) step();
    check("restart_hpix_held", 32'(hpix), 32'd0);
    check("restart_vram_lead", 32'(vram), 32'd1);
    step();
    check("restart_hpix_first_step", 32'(hpix), 32'd1);
    hde = 1'b0;
    vde = 1'b0;
    repeat (3) step();

    // Fast instance: two-cycle pixels, address tracks coordinates exactly.
    vde_b = 1'b1;
    repeat (3) step();
    check("b_vram_idle", 32'(vram_b), 32'd0);
    for (int l = 0; l < 2; l++) begin
      for (int k = 1; k <= 256; k++) begin
        hde_b = 1'b1;
        bexp_q.push_back((k / 2 > 127) ? 32'd127 : 32'(k / 2));
        step();
        e = bexp_q.pop_front();
        check("b_hpix", 32'(hpix_b), e);
        check("b_vram", 32'(vram_b), e);
      end
      for (int k = 0; k < 4; k++) begin
        hde_b = 1'b0;
        bexp_q.push_back(32'd0);
        step();
        e = bexp_q.pop_front();
        check("b_hpix_blank", 32'(hpix_b), e);
        check("b_vram_blank", 32'(vram_b), e);
      end
      check("b_vpix", 32'(vpix_b), 32'd0);
      check("b_overrun_exact_line", 32'(ovr_b), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pixel_addr_gen.md
# vga_pixel_addr_gen

Parametrised pixel-address generator for the VGA display path: converts display-enable strobes from the sync generator into the low-resolution pixel coordinates {VPIXEL, HPIXEL} and a VRAM read address. It is the successor to the fixed 128-pixel horizontal counter. Scaling is configurable on both axes, the VRAM address is prefetched to hide RAM read latency, and line/frame events and overrun status are reported.

## Interface
- H_PIX, 128: source pixels per line.
- V_PIX, 96: source lines per frame.
- H_SCALE, 5: screen dots per source pixel horizontally (128×5=640).
- V_SCALE, 5: screen lines per source line (96×5=480).
- CLK_PER_DOT, 4: clk cycles per screen dot.
- RAM_LAT, 2: clk cycles the VRAM address leads the pixel it selects. Legal range 0..PIX_CLKS-1.
- Derived widths and constants:
  - HW=$clog2(H_PIX), VW=$clog2(V_PIX).
  - PIX_CLKS=CLK_PER_DOT*H_SCALE (20 at defaults).
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- hde  in  1  horizontal display enable (active line region).
- vde  in  1  vertical display enable (active frame region).
- HPIXEL  out  HW  current source column.
- VPIXEL  out  VW  current source row.
- vram_addr  out  VW+HW  registered {row, column} VRAM read address, RAM_LAT cycles early.
- pixel_valid  out  1  hde & vde (combinational).
- line_done  out  1  one-cycle pulse after each active line ends.
- frame_done  out  1  one-cycle pulse after each active frame ends.
- pixel_overrun  out  1  sticky flag: hde held longer than H_PIX pixels, or vde held longer than V_PIX source lines.

## Operation
- Counters:
  - sub_cnt: 0..PIX_CLKS-1. Advances when hde&vde. Cleared when hde=0.
  - line_cnt: 0..V_SCALE-1. Counts screen lines within one source line.
  - HPIXEL, VPIXEL: source coordinates.
- Pixel tick: sub_cnt==PIX_CLKS-1 with hde&vde.
  - HPIXEL+1 on the tick.
  - HPIXEL saturates at H_PIX-1; a tick there sets pixel_overrun.
- Line end: detected as the hde falling edge (hde_q=1, hde=0) while vde=1.
  - HPIXEL←0; line_done pulses on the next cycle.
  - line_cnt+1, wrapping at V_SCALE-1. On the wrap, VPIXEL+1, saturating at V_PIX-1; a wrap at V_PIX-1 sets pixel_overrun.
- Frame end: vde falling edge.
  - VPIXEL, line_cnt, HPIXEL, sub_cnt ←0; frame_done pulses on the next cycle.
- vde=0: all counters held at 0; hde is ignored.
- Prefetch rules:
  - Fetch point: sub_cnt==PIX_CLKS-1-RAM_LAT during an active line. At the fetch point, vram_addr←{VPIXEL, min(HPIXEL+1, H_PIX-1)}.
  - hde=0: vram_addr←{VPIXEL_next, 0}. VPIXEL_next is the row the next line will display, so pixel 0 is ready when hde rises.
  - RAM_LAT=0: vram_addr updates on the same edge as HPIXEL.
- Precedence: reset > vde clear > line end > pixel tick.

## Timing
- Reset values: HPIXEL=0, VPIXEL=0, vram_addr=0, line_done=0, frame_done=0, pixel_overrun=0.
- First pixel: HPIXEL=0 for the first PIX_CLKS cycles of hde; it first becomes 1 on the edge ending cycle 20 (defaults).
- Address lead: vram_addr changes RAM_LAT cycles before the matching HPIXEL change.
- Pulses: line_done and frame_done are high for exactly one cycle, one cycle after the falling edge that triggers them.
- Simultaneous hde and vde fall: both line_done and frame_done pulse. VPIXEL clears; it does not increment.
- Reset mid-line: outputs clear asynchronously. After release, counting restarts only on the next hde&vde.
- Blanking: hde low ≥2 cycles (always true for VGA blanking).

## Structure
- Shared package vga_pkg holds:
  - H_PIX/V_PIX defaults and HW/VW width functions.
  - Address packing helper {row, col}.
- One sub-module, mod_counter: modulo-N counter with enable and sync clear, terminal-count output. Instantiated for sub_cnt and line_cnt.
- Top level holds HPIXEL/VPIXEL, edge detectors, prefetch register and flags.

## Test plan
- Reset, then a 640-dot hde window with vde=1 (defaults) → HPIXEL steps 0..127, each held 20 cycles; vram_addr leads each step by 2 cycles; pixel_overrun=0.
- 5 consecutive lines → VPIXEL=0 throughout. 6th line → VPIXEL=1. line_done pulses 6 times; vram_addr={1,0} before the 6th hde rise.
- hde held 2600 cycles → HPIXEL saturates at 127, pixel_overrun=1 and stays set until reset.
- hde and vde fall on the same cycle → line_done=frame_done=1 for one cycle; VPIXEL=0, HPIXEL=0.
- Assert reset at HPIXEL=64 mid-line → all outputs 0 immediately. Release with hde=1 → HPIXEL=1 after 20 cycles.
- Parameters H_SCALE=2, CLK_PER_DOT=1, RAM_LAT=0 → HPIXEL steps every 2 cycles; vram_addr equals {VPIXEL, HPIXEL} on every cycle.
